// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the memory access controller: FSM state encoding,
// access size / direction codes and small data-path helpers.
package mem_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    ACTIVE  = 3'd2,
    CAPTURE = 3'd3,
    RELEASE = 3'd4
  } state_t;

  localparam logic SIZE_BYTE = 1'b0;
  localparam logic SIZE_WORD = 1'b1;
  localparam logic DIR_READ  = 1'b1;
  localparam logic DIR_WRITE = 1'b0;

  // Width of the ACTIVE-state timeout counter (timeout range tops out at 255)
  localparam int CNT_W = 8;

  // A word access must sit on a 4-byte boundary
  function automatic logic is_misaligned(input logic word_byte, input logic [7:0] addr);
    if (word_byte == SIZE_WORD) begin
      return (addr[1:0] != 2'b00);
    end else begin
      return 1'b0;
    end
  endfunction

  // Word passes through; byte keeps lane 0 and zero-extends
  function automatic logic [31:0] size_extend(input logic word_byte, input logic [31:0] value);
    if (word_byte == SIZE_WORD) begin
      return value;
    end else begin
      return {24'h000000, value[7:0]};
    end
  endfunction

endpackage

// File: rtl/mfc_sync.sv
// Two-flop synchronizer for the memory function-complete handshake.
// Only instantiated when MEM_ACCESS_MFC_SYNC_EN is defined.
module mfc_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic mfc_async,
  output logic mfc_synced
);

  logic [1:0] sync_r;

  // Shift the asynchronous MFC through two flops to settle metastability
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r <= 2'b00;
    end else begin
      sync_r <= {sync_r[0], mfc_async};
    end
  end

  assign mfc_synced = sync_r[1];

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory access controller: turns a single Start request into an
// MFA/MFC handshake with a byte-addressed memory, with alignment checking,
// an ACTIVE-state timeout and a one-cycle Done/Err completion pulse.
// Optional macro MEM_ACCESS_MFC_SYNC_EN adds a two-flop MFC synchronizer.
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic        RW,
  input  logic        WordByte,
  input  logic [7:0]  AddrIn,
  input  logic [31:0] WrData,
  output logic [31:0] RdData,
  output logic        Busy,
  output logic        Done,
  output logic        Err,
  output logic        MFA,
  output logic        ReadWrite,
  output logic [7:0]  Address,
  output logic        wordByte,
  input  logic        MFC,
  inout  wire  [31:0] Data
);

  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t            state_r;
  logic              mfa_r;
  logic              rw_r;
  logic              wb_r;
  logic [7:0]        addr_r;
  logic              data_oe_r;
  logic [31:0]       data_out_r;
  logic [31:0]       rd_data_r;
  logic              busy_r;
  logic              done_r;
  logic              err_r;
  logic              timeout_r;
  logic [CNT_W-1:0]  cnt_r;
  logic              mfc_s;

`ifdef MEM_ACCESS_MFC_SYNC_EN
  mfc_sync u_mfc_sync (
    .clk        (Clk),
    .rst_n      (Reset),
    .mfc_async  (MFC),
    .mfc_synced (mfc_s)
  );
`else
  assign mfc_s = MFC;
`endif

  // Access sequencer: all handshake outputs come straight from registers
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_r    <= IDLE;
      mfa_r      <= 1'b0;
      rw_r       <= DIR_READ;
      wb_r       <= SIZE_WORD;
      addr_r     <= 8'h00;
      data_oe_r  <= 1'b0;
      data_out_r <= 32'h0000_0000;
      rd_data_r  <= 32'h0000_0000;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      err_r      <= 1'b0;
      timeout_r  <= 1'b0;
      cnt_r      <= '0;
    end else begin
      done_r <= 1'b0;
      err_r  <= 1'b0;
      case (state_r)
        IDLE: begin
          // A request landing in the Done cycle is dropped, not queued
          if (Start && !done_r) begin
            if (is_misaligned(WordByte, AddrIn)) begin
              done_r <= 1'b1;
              err_r  <= 1'b1;
            end else begin
              state_r    <= SETUP;
              rw_r       <= RW;
              wb_r       <= WordByte;
              addr_r     <= AddrIn;
              data_out_r <= size_extend(WordByte, WrData);
              data_oe_r  <= (RW == DIR_WRITE);
              busy_r     <= 1'b1;
              timeout_r  <= 1'b0;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        SETUP: begin
          // Address/direction/size have been stable for a full cycle
          state_r <= ACTIVE;
          mfa_r   <= 1'b1;
          cnt_r   <= '0;
        end
        ACTIVE: begin
          if (mfc_s) begin
            cnt_r     <= '0;
            data_oe_r <= 1'b0;
            if (rw_r == DIR_READ) begin
              state_r <= CAPTURE;
            end else begin
              state_r <= RELEASE;
              mfa_r   <= 1'b0;
            end
          end else if (cnt_r == TIMEOUT_LAST) begin
            state_r   <= RELEASE;
            mfa_r     <= 1'b0;
            data_oe_r <= 1'b0;
            timeout_r <= 1'b1;
            cnt_r     <= '0;
          end else begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        CAPTURE: begin
          // Memory is still driving the bus because MFA is still high here
          rd_data_r <= size_extend(wb_r, Data);
          mfa_r     <= 1'b0;
          state_r   <= RELEASE;
        end
        RELEASE: begin
          if (!mfc_s) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            err_r   <= timeout_r;
          end else begin
            state_r <= RELEASE;
          end
        end
        default: begin
          state_r   <= IDLE;
          mfa_r     <= 1'b0;
          data_oe_r <= 1'b0;
          busy_r    <= 1'b0;
          cnt_r     <= '0;
        end
      endcase
    end
  end

  assign RdData    = rd_data_r;
  assign Busy      = busy_r;
  assign Done      = done_r;
  assign Err       = err_r;
  assign MFA       = mfa_r;
  assign ReadWrite = rw_r;
  assign Address   = addr_r;
  assign wordByte  = wb_r;
  assign Data      = data_oe_r ? data_out_r : {32{1'bz}};

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a byte-addressed big-endian
// memory model and a scoreboard of expected completions.
module tb_mem_access_ctrl;

`ifdef MEM_ACCESS_MFC_SYNC_EN
  localparam int SE = 4;
`else
  localparam int SE = 0;
`endif

  logic        Clk;
  logic        Reset;
  logic        Start;
  logic        RW;
  logic        WordByte;
  logic [7:0]  AddrIn;
  logic [31:0] WrData;
  logic [31:0] RdData;
  logic        Busy;
  logic        Done;
  logic        Err;
  logic        MFA;
  logic        ReadWrite;
  logic [7:0]  Address;
  logic        wordByte;
  logic        MFC;
  wire  [31:0] data_bus;

  logic [7:0]  mem [0:255];
  logic        mem_resp_en;
  logic        probe_en;
  logic [31:0] mem_rd;

  int n_tests = 0;
  int n_fail  = 0;

  int          mfa_rises = 0;
  int          mfa_high  = 0;
  int          done_cnt  = 0;
  logic        mfa_prev  = 1'b0;
  logic [31:0] last_wr_bus = 32'h0;

  typedef struct {
    logic [31:0] rd;
    logic        err;
    int          lat;
  } exp_t;
  exp_t sb[$];

  mem_access_ctrl #(.TIMEOUT_CYCLES(15)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .RW(RW), .WordByte(WordByte),
    .AddrIn(AddrIn), .WrData(WrData), .RdData(RdData), .Busy(Busy),
    .Done(Done), .Err(Err), .MFA(MFA), .ReadWrite(ReadWrite),
    .Address(Address), .wordByte(wordByte), .MFC(MFC), .Data(data_bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic logic [7:0] pat(input int i);
    case (i)
      8:       return 8'hDE;
      9:       return 8'hAD;
      10:      return 8'hBE;
      11:      return 8'hEF;
      default: return 8'(i) ^ 8'h3C;
    endcase
  endfunction

  // Memory model: immediate MFC, big-endian words, drives bus on reads only
  assign MFC    = MFA & mem_resp_en;
  assign mem_rd = wordByte ? {mem[Address], mem[Address + 8'd1], mem[Address + 8'd2], mem[Address + 8'd3]}
                           : {24'h0, mem[Address]};
  assign data_bus = (MFA && ReadWrite) ? mem_rd : {32{1'bz}};
  assign data_bus = probe_en ? 32'h0000_0000 : {32{1'bz}};

  always @(posedge Clk) begin
    if (!Reset) begin
      for (int i = 0; i < 256; i++) mem[i] <= pat(i);
    end else if (MFA && MFC && !ReadWrite) begin
      if (wordByte) begin
        mem[Address]        <= data_bus[31:24];
        mem[Address + 8'd1] <= data_bus[23:16];
        mem[Address + 8'd2] <= data_bus[15:8];
        mem[Address + 8'd3] <= data_bus[7:0];
      end else begin
        mem[Address] <= data_bus[7:0];
      end
    end
  end

  // Event counters observed at the falling edge
  always @(negedge Clk) begin
    if (MFA === 1'b1 && mfa_prev === 1'b0) mfa_rises <= mfa_rises + 1;
    if (MFA === 1'b1) mfa_high <= mfa_high + 1;
    if (Done === 1'b1) done_cnt <= done_cnt + 1;
    if (MFA === 1'b1 && ReadWrite === 1'b0) last_wr_bus <= data_bus;
    mfa_prev <= MFA;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic probe_z(input string tag);
    probe_en = 1'b1;
    #1;
    chk(tag, data_bus, 32'h0000_0000);
    probe_en = 1'b0;
    #1;
  endtask

  task automatic do_access(input string tag, input logic rw, input logic wb, input logic [7:0] addr,
                           input logic [31:0] wdata, input logic [31:0] exp_rd, input logic exp_err,
                           input int exp_lat);
    exp_t e;
    exp_t got;
    int   lat;
    logic seen;
    e.rd = exp_rd; e.err = exp_err; e.lat = exp_lat;
    sb.push_back(e);
    @(negedge Clk);
    Start = 1'b1; RW = rw; WordByte = wb; AddrIn = addr; WrData = wdata;
    lat = 0; seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge Clk);
      Start = 1'b0;
      lat++;
      if (lat == 1) chk({tag, "_busy"}, {31'h0, Busy}, {31'h0, (exp_lat > 1)});
      if (Done === 1'b1) seen = 1'b1;
    end
    chk({tag, "_done_seen"}, {31'h0, seen}, 32'h1);
    got = sb.pop_front();
    chk({tag, "_latency"}, lat, got.lat);
    chk({tag, "_rddata"}, RdData, got.rd);
    chk({tag, "_err"}, {31'h0, Err}, {31'h0, got.err});
    @(negedge Clk);
    chk({tag, "_done_pulse"}, {30'h0, Done, Err}, 32'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0, d0, h0;
    Reset = 1'b0; Start = 1'b0; RW = 1'b1; WordByte = 1'b1; AddrIn = 8'h00;
    WrData = 32'h0; mem_resp_en = 1'b1; probe_en = 1'b0;
    repeat (3) @(negedge Clk);
    #1;
    chk("rst_outputs", {MFA, Busy, Done, Err, ReadWrite, wordByte}, 32'h03);
    chk("rst_rddata", RdData, 32'h0);
    chk("rst_address", {24'h0, Address}, 32'h0);
    probe_z("rst_data_z");
    @(negedge Clk);
    Reset = 1'b1;

    // Reads; WrData all-ones so any stray DUT drive corrupts the read
    do_access("rd_word8", 1'b1, 1'b1, 8'd8, 32'hFFFF_FFFF, 32'hDEAD_BEEF, 1'b0, 5 + SE);
    do_access("rd_byte9", 1'b1, 1'b0, 8'd9, 32'hFFFF_FFFF, 32'h0000_00AD, 1'b0, 5 + SE);

    // Byte write puts only lane 0 on the bus
    do_access("wr_byte20", 1'b0, 1'b0, 8'd20, 32'h1234_5678, 32'h0000_00AD, 1'b0, 4 + SE);
    #1;
    chk("wr_byte20_bus", last_wr_bus, 32'h0000_0078);
    chk("wr_byte20_mem", {24'h0, mem[20]}, 32'h78);
    chk("wr_byte20_neighbor", {24'h0, mem[21]}, {24'h0, pat(21)});
    probe_z("wr_idle_data_z");

    do_access("wr_word12", 1'b0, 1'b1, 8'd12, 32'hCAFE_F00D, 32'h0000_00AD, 1'b0, 4 + SE);
    #1;
    chk("wr_word12_bus", last_wr_bus, 32'hCAFE_F00D);
    chk("wr_word12_mem", {mem[12], mem[13], mem[14], mem[15]}, 32'hCAFE_F00D);
    do_access("rd_word12", 1'b1, 1'b1, 8'd12, 32'h0, 32'hCAFE_F00D, 1'b0, 5 + SE);

    // Misaligned word: immediate error, no handshake
    #1; r0 = mfa_rises;
    do_access("misalign5", 1'b1, 1'b1, 8'h05, 32'h0, 32'hCAFE_F00D, 1'b1, 1);
    #1;
    chk("misalign5_no_mfa", mfa_rises - r0, 0);
    do_access("rd_byte5", 1'b1, 1'b0, 8'h05, 32'h0, {24'h0, pat(5)}, 1'b0, 5 + SE);
    do_access("rd_word252", 1'b1, 1'b1, 8'd252, 32'h0, 32'hC0C1_C2C3, 1'b0, 5 + SE);

    // Timeout: memory never answers
    mem_resp_en = 1'b0;
    #1; h0 = mfa_high;
    do_access("timeout", 1'b1, 1'b1, 8'd16, 32'h0, 32'hC0C1_C2C3, 1'b1, 18);
    #1;
    chk("timeout_mfa_cycles", mfa_high - h0, 15);
    mem_resp_en = 1'b1;

    // Start during ACTIVE and through the Done cycle must be ignored
    mem_resp_en = 1'b0;
    @(negedge Clk); #1;
    r0 = mfa_rises; d0 = done_cnt;
    Start = 1'b1; RW = 1'b1; WordByte = 1'b1; AddrIn = 8'd8;
    @(negedge Clk); Start = 1'b0;
    repeat (2) @(negedge Clk);
    Start = 1'b1; AddrIn = 8'd16;
    repeat (2) @(negedge Clk);
    mem_resp_en = 1'b1;
    begin
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
        @(negedge Clk);
        if (Done === 1'b1) seen = 1'b1;
      end
      chk("ignore_done_seen", {31'h0, seen}, 32'h1);
    end
    @(negedge Clk); Start = 1'b0;
    repeat (3) @(negedge Clk);
    #1;
    chk("ignore_one_mfa", mfa_rises - r0, 1);
    chk("ignore_one_done", done_cnt - d0, 1);
    chk("ignore_rddata", RdData, 32'hDEAD_BEEF);
    chk("ignore_address", {24'h0, Address}, 32'd8);
    chk("ignore_not_busy", {31'h0, Busy}, 32'h0);

    // Reset in the middle of a write stuck in ACTIVE
    mem_resp_en = 1'b0;
    @(negedge Clk);
    Start = 1'b1; RW = 1'b0; WordByte = 1'b1; AddrIn = 8'd12; WrData = 32'h1122_3344;
    @(negedge Clk); Start = 1'b0;
    repeat (2) @(negedge Clk);
    chk("midrst_pre_mfa", {31'h0, MFA}, 32'h1);
    Reset = 1'b0;
    #1;
    chk("midrst_outputs", {MFA, Busy, Done, Err, ReadWrite, wordByte}, 32'h03);
    chk("midrst_rddata", RdData, 32'h0);
    chk("midrst_address", {24'h0, Address}, 32'h0);
    probe_z("midrst_data_z");
    repeat (2) @(negedge Clk);
    Reset = 1'b1;
    mem_resp_en = 1'b1;
    do_access("post_rst_rd", 1'b1, 1'b1, 8'd8, 32'hFFFF_FFFF, 32'hDEAD_BEEF, 1'b0, 5 + SE);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
